// File: rtl/ps2_mouse_pkt_pkg.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt_pkg : shared frame-state enum, status-bit and word-field indices
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_mouse_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam int c_stat_left    = 0;
  localparam int c_stat_right   = 1;
  localparam int c_stat_middle  = 2;
  localparam int c_stat_always1 = 3;
  localparam int c_stat_xsign   = 4;
  localparam int c_stat_ysign   = 5;
  localparam int c_stat_xovf    = 6;
  localparam int c_stat_yovf    = 7;

  localparam int c_word_w     = 25;
  localparam int c_toggle_bit = 24;
  localparam int c_y_lsb      = 16;
  localparam int c_x_lsb      = 8;
  localparam int c_stat_lsb   = 0;

endpackage

`default_nettype wire

// File: rtl/ps2_mouse_pkt_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt_if : PS/2 line inputs and decoded packet outputs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ps2_mouse_pkt_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [24:0] ps2_mouse;
  logic        frame_err;

  modport master (output ps2_clk, output ps2_data, input ps2_mouse, input frame_err);
  modport slave  (input ps2_clk, input ps2_data, output ps2_mouse, output frame_err);
endinterface

`default_nettype wire

// File: rtl/ps2_mouse_pkt_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx : PS/2 synchronizer, clock glitch filter, frame FSM, bit timeout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_frame_rx
  import ps2_mouse_pkt_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(BIT_TIMEOUT + 1);

  logic [1:0]   clk_sync_q, data_sync_q;
  logic         filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  frame_state_e state_q, state_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         w_clk_s, w_data_s, w_fall;

  assign w_clk_s  = clk_sync_q[1];
  assign w_data_s = data_sync_q[1];
  assign byte_o   = shreg_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
    end
  end

  // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (w_clk_s != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = w_clk_s;
      else filt_cnt_d = filt_cnt_q + FW'(1);
    end
  end

  assign w_fall = filt_q & ~filt_d;

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_ok_d     = par_ok_q;
    tmo_d        = '0;
    byte_valid_o = 1'b0;
    err_o        = 1'b0;
    if (w_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!w_data_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {w_data_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_ok_d = ^{shreg_q, w_data_s};
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (w_data_s && par_ok_q) byte_valid_o = 1'b1;
          else err_o = 1'b1;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // Counter stops at the limit and the frame is abandoned there.
      if (tmo_q >= TW'(BIT_TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        err_o   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_mouse_pkt.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt : assembles three PS/2 mouse bytes into a 25-bit packet word
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_pkt
  import ps2_mouse_pkt_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int BIT_TIMEOUT = 50000,
  parameter int PKT_TIMEOUT = 1000000
) (
  input logic            clk,
  input logic            reset_n,
  ps2_mouse_pkt_if.slave bus
);

  localparam int PW = $clog2(PKT_TIMEOUT + 1);

  logic [7:0]          w_byte;
  logic                w_valid, w_err;
  logic [1:0]          idx_q, idx_d;
  logic [7:0]          b0_q, b0_d, b1_q, b1_d;
  logic [c_word_w-1:0] word_q, word_d;
  logic                ferr_q, ferr_d;
  logic [PW-1:0]       ptmo_q, ptmo_d;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .BIT_TIMEOUT (BIT_TIMEOUT)
  ) u_frame_rx (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .ps2_clk_i    (bus.ps2_clk),
    .ps2_data_i   (bus.ps2_data),
    .byte_o       (w_byte),
    .byte_valid_o (w_valid),
    .err_o        (w_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      b0_q   <= '0;
      b1_q   <= '0;
      word_q <= '0;
      ferr_q <= 1'b0;
      ptmo_q <= '0;
    end else begin
      idx_q  <= idx_d;
      b0_q   <= b0_d;
      b1_q   <= b1_d;
      word_q <= word_d;
      ferr_q <= ferr_d;
      ptmo_q <= ptmo_d;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    b0_d   = b0_q;
    b1_d   = b1_q;
    word_d = word_q;
    ferr_d = 1'b0;
    ptmo_d = '0;
    if (w_err) begin
      ferr_d = 1'b1;
      idx_d  = '0;
    end else if (w_valid) begin
      case (idx_q)
        2'd0: begin
          // A first byte without the always-one bit means we are out of step.
          if (w_byte[c_stat_always1]) begin
            b0_d  = w_byte;
            idx_d = 2'd1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        2'd1: begin
          b1_d  = w_byte;
          idx_d = 2'd2;
        end
        default: begin
          word_d[c_toggle_bit]     = ~word_q[c_toggle_bit];
          word_d[c_y_lsb +: 8]     = w_byte;
          word_d[c_x_lsb +: 8]     = b1_q;
          word_d[c_stat_lsb +: 8]  = b0_q;
          idx_d                    = '0;
        end
      endcase
    end else if (idx_q != 2'd0) begin
      if (ptmo_q >= PW'(PKT_TIMEOUT - 1)) idx_d = '0;
      else ptmo_d = ptmo_q + PW'(1);
    end
  end

  assign bus.ps2_mouse = word_q;
  assign bus.frame_err = ferr_q;

endmodule

`default_nettype wire
